alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter MUL_LAT, default 2, meaning: EXEC cycles for mul (ctrl 3'b101), legal range 1..7.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 reqN_valid_i  input  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_a_i, reqN_b_i  input  32 each  signed operands of requester N.
REQ-006 reqN_ctrl_i  input  3  ALU opcode of requester N: 000 add, 001 and, 010 xor, 011 sll, 100 sub, 101 mul, 110 srai.
REQ-007 reqN_ready_o  output  1  operation of requester N accepted this cycle.
REQ-008 rspN_valid_o  output  1  one-cycle pulse: result for requester N valid.
REQ-009 rspN_data_o  output  32  result for requester N.
REQ-010 alu_a_o, alu_b_o  output  32 each  operands driven to the shared ALU.
REQ-011 alu_ctrl_o  output  3  opcode driven to the shared ALU.
REQ-012 alu_data_i  input  32  combinational result from the shared ALU.
REQ-013 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; exactly one operation in flight at any time.
REQ-015 Handshake: a transfer occurs on a cycle with reqN_valid_i=1 and reqN_ready_o=1; requester holds valid, operands and ctrl stable until then.
REQ-016 reqN_ready_o SHALL be combinational: high only in IDLE, for the granted requester, never both high in one cycle.
REQ-017 Grant in IDLE: only one valid -> that one; both valid -> the requester not granted most recently; after reset req0 wins a tie.
REQ-018 On transfer: operands, ctrl and grant id registered; last-grant pointer updated; state -> EXEC; counter loaded with MUL_LAT-1 if ctrl=101, else 0.
REQ-019 EXEC: alu_a_o/alu_b_o/alu_ctrl_o driven from the registered operation every EXEC cycle; counter>0 -> decrement, stay; counter=0 -> capture alu_data_i into result register, -> RESP.
REQ-020 RESP: rspN_valid_o high for exactly one cycle for the granted N, rspN_data_o = captured result; -> IDLE; no response back-pressure.
REQ-021 Latency from transfer edge T: non-mul response valid in cycle T+2; mul in cycle T+1+MUL_LAT.
REQ-022 Throughput: a new transfer is possible in the IDLE cycle after RESP; a held request is granted in that cycle (min 3 cycles/op non-mul).
REQ-023 In IDLE and RESP, alu_a_o, alu_b_o, alu_ctrl_o SHALL be 0.
REQ-024 rspN_data_o of the non-granted requester SHALL be 0; rspN_data_o SHALL be 0 whenever rspN_valid_o=0.
REQ-025 Opcode 111 SHALL be forwarded unchanged, single EXEC cycle; result is whatever alu_data_i returns (0 from the team ALU).
REQ-026 Valid deasserted by a requester before grant SHALL be ignored (no response generated).
REQ-027 No arithmetic in this block; results pass through at full 32 bits unmodified.

Reset
REQ-028 rst_i=1 SHALL immediately force state IDLE, counter 0, last-grant pointer to req1 (so req0 wins first tie), result/operand registers 0, and all outputs 0.
REQ-029 Reset mid-operation SHALL discard the in-flight operation; no rspN_valid_o pulse for it after reset release.
REQ-030 First grant possible in the first rising edge after rst_i deasserts.

Verification
REQ-031 req0 add a=5, b=7 alone -> req0_ready_o at T, alu_ctrl_o=000 at T+1, rsp0_valid_o=1 with data 12 at T+2 only.
REQ-032 Both valid from reset, req0 sub 10-3, req1 xor 0xF0^0x0F -> req0 granted first, rsp0=7; req1 granted next IDLE, rsp1=0xFF; repeat tie -> req0 granted (alternation).
REQ-033 req1 mul a=-3, b=4, MUL_LAT=2 -> EXEC 2 cycles, rsp1_valid_o at T+3 with 0xFFFFFFF4; busy_o high T+1..T+3.
REQ-034 req0 srai a=0x80000000, b=4 -> rsp0_data_o=0xF8000000; req0 sll a=1, b=33 -> 2 (ALU uses b[4:0]).
REQ-035 rst_i pulsed during EXEC of a mul -> all outputs 0 asynchronously, no rsp pulse afterwards, next request completes normally.
REQ-036 req1 valid dropped one cycle before grant while busy -> no req1 transfer, no rsp1 pulse.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU: grants one
// operation at a time (round-robin on ties), holds it in EXEC, returns a one-cycle response.
module alu_arbiter #(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req0_valid_i,
   input  logic [31:0] req0_a_i,
   input  logic [31:0] req0_b_i,
   input  logic [2:0]  req0_ctrl_i,
   output logic        req0_ready_o,
   input  logic        req1_valid_i,
   input  logic [31:0] req1_a_i,
   input  logic [31:0] req1_b_i,
   input  logic [2:0]  req1_ctrl_i,
   output logic        req1_ready_o,
   output logic        rsp0_valid_o,
   output logic [31:0] rsp0_data_o,
   output logic        rsp1_valid_o,
   output logic [31:0] rsp1_data_o,
   output logic [31:0] alu_a_o,
   output logic [31:0] alu_b_o,
   output logic [2:0]  alu_ctrl_o,
   input  logic [31:0] alu_data_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [2:0] OP_MUL = 3'b101;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        last_q, last_d;
   logic        gid_q, gid_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] res_q, res_d;

   logic        gnt_vld;
   logic        gnt;
   logic [31:0] sel_a;
   logic [31:0] sel_b;
   logic [2:0]  sel_ctrl;

   // On a tie the requester that was not served last wins.
   always_comb begin
      gnt_vld = req0_valid_i | req1_valid_i;
      if (req0_valid_i && req1_valid_i) begin
         gnt = ~last_q;
      end else begin
         gnt = req1_valid_i;
      end
      sel_a    = gnt ? req1_a_i    : req0_a_i;
      sel_b    = gnt ? req1_b_i    : req0_b_i;
      sel_ctrl = gnt ? req1_ctrl_i : req0_ctrl_i;
   end

   assign req0_ready_o = ~rst_i & (state_q == IDLE) & gnt_vld & ~gnt;
   assign req1_ready_o = ~rst_i & (state_q == IDLE) & gnt_vld &  gnt;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      gid_d   = gid_q;
      a_d     = a_q;
      b_d     = b_q;
      ctrl_d  = ctrl_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               a_d     = sel_a;
               b_d     = sel_b;
               ctrl_d  = sel_ctrl;
               gid_d   = gnt;
               last_d  = gnt;
               cnt_d   = (sel_ctrl == OP_MUL) ? 3'(MUL_LAT - 1) : 3'd0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               res_d   = alu_data_i;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         last_q  <= 1'b1;
         gid_q   <= 1'b0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         ctrl_q  <= 3'd0;
         res_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         gid_q   <= gid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctrl_q  <= ctrl_d;
         res_q   <= res_d;
      end
   end

   // Outputs decode straight from registered state, so they drop the moment reset forces IDLE.
   assign busy_o       = (state_q != IDLE);
   assign alu_a_o      = (state_q == EXEC) ? a_q    : 32'd0;
   assign alu_b_o      = (state_q == EXEC) ? b_q    : 32'd0;
   assign alu_ctrl_o   = (state_q == EXEC) ? ctrl_q : 3'd0;
   assign rsp0_valid_o = (state_q == RESP) & ~gid_q;
   assign rsp1_valid_o = (state_q == RESP) &  gid_q;
   assign rsp0_data_o  = rsp0_valid_o ? res_q : 32'd0;
   assign rsp1_data_o  = rsp1_valid_o ? res_q : 32'd0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared ALU.
module tb_alu_arbiter;

   localparam int MUL_LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        r0_v = 1'b0, r1_v = 1'b0;
   logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
   logic [2:0]  r0_c = '0, r1_c = '0;
   logic        r0_rdy, r1_rdy, s0_v, s1_v, busy;
   logic [31:0] s0_d, s1_d, alu_a, alu_b, alu_d;
   logic [2:0]  alu_c;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.MUL_LAT(MUL_LAT)) dut (
      .clk_i(clk), .rst_i(rst),
      .req0_valid_i(r0_v), .req0_a_i(r0_a), .req0_b_i(r0_b), .req0_ctrl_i(r0_c), .req0_ready_o(r0_rdy),
      .req1_valid_i(r1_v), .req1_a_i(r1_a), .req1_b_i(r1_b), .req1_ctrl_i(r1_c), .req1_ready_o(r1_rdy),
      .rsp0_valid_o(s0_v), .rsp0_data_o(s0_d), .rsp1_valid_o(s1_v), .rsp1_data_o(s1_d),
      .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_ctrl_o(alu_c), .alu_data_i(alu_d), .busy_o(busy)
   );

   always_comb begin
      case (alu_c)
         3'b000:  alu_d = alu_a + alu_b;
         3'b001:  alu_d = alu_a & alu_b;
         3'b010:  alu_d = alu_a ^ alu_b;
         3'b011:  alu_d = alu_a << alu_b[4:0];
         3'b100:  alu_d = alu_a - alu_b;
         3'b101:  alu_d = alu_a * alu_b;
         3'b110:  alu_d = $signed(alu_a) >>> alu_b[4:0];
         default: alu_d = 32'd0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input int rq, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c);
      if (rq == 0) begin r0_v = v; r0_a = a; r0_b = b; r0_c = c; end
      else         begin r1_v = v; r1_a = a; r1_b = b; r1_c = c; end
   endtask

   // Wait (from a negedge in cycle T+1) for the response of requester rq; returns its cycle offset from T.
   task automatic wait_rsp(input int rq, output int lat, output logic [31:0] dat);
      lat = 1;
      dat = '0;
      while (lat < 20) begin
         if ((rq == 0 && s0_v) || (rq == 1 && s1_v)) begin
            dat = (rq == 0) ? s0_d : s1_d;
            return;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   typedef struct {
      int          rq;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  c;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   task automatic run_op(input vec_t v);
      int          lat;
      logic [31:0] dat;
      @(negedge clk);
      drive(v.rq, 1'b1, v.a, v.b, v.c);
      #1;
      chk("ready", (v.rq == 0) ? r0_rdy : r1_rdy, 1'b1);
      chk("other_ready", (v.rq == 0) ? r1_rdy : r0_rdy, 1'b0);
      @(negedge clk);
      drive(v.rq, 1'b0, 32'd0, 32'd0, 3'd0);
      chk("exec_ctrl", {29'd0, alu_c}, {29'd0, v.c});
      chk("exec_busy", busy, 1'b1);
      wait_rsp(v.rq, lat, dat);
      chk("latency", lat, v.lat);
      chk("rsp_data", dat, v.exp);
      chk("other_rsp_data", (v.rq == 0) ? s1_d : s0_d, 32'd0);
      @(negedge clk);
      chk("rsp_one_pulse", {s0_v, s1_v, busy}, 3'b000);
      chk("idle_alu", alu_a | alu_b | {29'd0, alu_c}, 32'd0);
   endtask

   initial begin
      int          lat;
      logic [31:0] dat;
      int          seen;

      vecs[0] = '{0, 32'd5,        32'd7,        3'b000, 32'd12,        2};
      vecs[1] = '{0, 32'h8000_0000, 32'd4,       3'b110, 32'hF800_0000, 2};
      vecs[2] = '{0, 32'd1,        32'd33,       3'b011, 32'd2,         2};
      vecs[3] = '{1, 32'hFFFF_FFFD, 32'd4,       3'b101, 32'hFFFF_FFF4, MUL_LAT + 1};
      vecs[4] = '{1, 32'hFF00_FF00, 32'h0F0F_0F0F, 3'b001, 32'h0F00_0F00, 2};
      vecs[5] = '{1, 32'h1234_5678, 32'h1111_1111, 3'b100, 32'h0123_4567, 2};
      vecs[6] = '{1, 32'hDEAD_BEEF, 32'h1,       3'b111, 32'd0,         2};
      vecs[7] = '{0, 32'h7FFF_FFFF, 32'd1,       3'b000, 32'h8000_0000, 2};

      // Reset holds every output low even with a request pending.
      r0_v = 1'b1;
      #12;
      chk("rst_ready0", r0_rdy, 1'b0);
      chk("rst_outs", {31'd0, busy | s0_v | s1_v} | alu_a | alu_b | s0_d | s1_d, 32'd0);
      @(negedge clk);
      r0_v = 1'b0;
      rst  = 1'b0;

      // Tie straight out of reset: req0 first, held req1 next, then alternation.
      @(negedge clk);
      drive(0, 1'b1, 32'd10, 32'd3, 3'b100);
      drive(1, 1'b1, 32'hF0, 32'h0F, 3'b010);
      #1;
      chk("tie_r0_rdy", {r0_rdy, r1_rdy}, 2'b10);
      @(negedge clk);
      drive(0, 1'b0, 32'd0, 32'd0, 3'd0);
      wait_rsp(0, lat, dat);
      chk("tie_rsp0_lat", lat, 2);
      chk("tie_rsp0", dat, 32'd7);
      chk("tie_rsp1_quiet", {31'd0, s1_v}, 32'd0);
      @(negedge clk);
      chk("held_r1_rdy", {r0_rdy, r1_rdy}, 2'b01);
      @(negedge clk);
      drive(1, 1'b0, 32'd0, 32'd0, 3'd0);
      wait_rsp(1, lat, dat);
      chk("tie_rsp1_lat", lat, 2);
      chk("tie_rsp1", dat, 32'hFF);
      @(negedge clk);
      drive(0, 1'b1, 32'd1, 32'd1, 3'b000);
      drive(1, 1'b1, 32'd2, 32'd2, 3'b000);
      #1;
      chk("tie2_r0_rdy", {r0_rdy, r1_rdy}, 2'b10);
      @(negedge clk);
      drive(0, 1'b0, 32'd0, 32'd0, 3'd0);
      wait_rsp(0, lat, dat);
      chk("tie2_rsp0", dat, 32'd2);
      @(negedge clk);
      chk("tie2_r1_rdy", {r0_rdy, r1_rdy}, 2'b01);
      @(negedge clk);
      drive(1, 1'b0, 32'd0, 32'd0, 3'd0);
      wait_rsp(1, lat, dat);
      chk("tie2_rsp1", dat, 32'd4);
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i]);
      end

      // Mul: busy through both EXEC cycles and RESP.
      @(negedge clk);
      drive(1, 1'b1, 32'hFFFF_FFFD, 32'd4, 3'b101);
      @(negedge clk);
      drive(1, 1'b0, 32'd0, 32'd0, 3'd0);
      chk("mul_busy_t1", busy, 1'b1);
      @(negedge clk);
      chk("mul_busy_t2", {busy, s1_v}, 2'b10);
      @(negedge clk);
      chk("mul_rsp_t3", {busy, s1_v}, 2'b11);
      chk("mul_data_t3", s1_d, 32'hFFFF_FFF4);
      @(negedge clk);

      // Reset in the middle of a mul drops it silently.
      @(negedge clk);
      drive(1, 1'b1, 32'd6, 32'd7, 3'b101);
      @(negedge clk);
      drive(1, 1'b0, 32'd0, 32'd0, 3'd0);
      chk("pre_rst_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_async_busy", busy, 1'b0);
      chk("rst_async_alu", alu_a | alu_b | {29'd0, alu_c}, 32'd0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (s0_v || s1_v || busy) seen++;
      end
      chk("no_rsp_after_rst", seen, 0);
      run_op('{1, 32'd6, 32'd7, 3'b101, 32'd42, MUL_LAT + 1});

      // req1 valid withdrawn before it could be granted.
      @(negedge clk);
      drive(0, 1'b1, 32'd3, 32'd4, 3'b000);
      @(negedge clk);
      drive(0, 1'b0, 32'd0, 32'd0, 3'd0);
      drive(1, 1'b1, 32'd9, 32'd9, 3'b000);
      #1;
      chk("busy_no_r1_rdy", r1_rdy, 1'b0);
      @(negedge clk);
      drive(1, 1'b0, 32'd0, 32'd0, 3'd0);
      chk("drop_rsp0", s0_d, 32'd7);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (r1_rdy || s1_v || busy) seen++;
      end
      chk("dropped_ignored", seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
